// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the two-requester cache arbiter.
// Holds the FSM state encoding, the requester id type and the default parameters.
// Imported by cache_arbiter and rr_pick2.
package cache_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID_0 = 1'b0;
  localparam req_id_t REQ_ID_1 = 1'b1;

endpackage

// File: rtl/cache_arbiter_rr_pick2.sv
// Two-way round-robin pick: purely combinational, one-hot grant out.
// A lone requester always wins; on a tie the requester not granted last wins.
// No state here; the last-grant pointer is held by the caller.
module rr_pick2
  import cache_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_id_t    i_last,
  output logic [1:0] o_gnt
);

  // Select the winner from the request vector and last-grant pointer
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_last == REQ_ID_1) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter granting two requesters one access at a time to a direct-mapped cache.
// Latency: request seen in IDLE -> valid_req next cycle; done one cycle after cache_ready is sampled.
// Backpressure: requests are levels held until done; the cache paces via cache_ready.
// Optional build macro CACHE_ARB_TIMEOUT_EN adds a WAIT watchdog that forces completion with err.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              cache_valid_req,
  output logic              cache_rw,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_data_in,
  input  logic              cache_ready,
  input  logic [DATA_W-1:0] cache_data_out,
  input  logic              cache_hit,
  input  logic              cache_miss,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic              busy,
  output logic              err
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  req_id_t           r_owner;
  req_id_t           r_last;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done0;
  logic              r_done1;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_grant_any;
  req_id_t           w_gnt_id;
  logic              w_complete;
  logic              w_timeout;
  logic              w_finish;

  // The owner is still holding req during its done cycle; mask it so it cannot be re-granted there
  assign w_req       = {r1_req & ~r_done1, r0_req & ~r_done0};
  assign w_grant_any = |w_gnt;
  assign w_gnt_id    = req_id_t'(w_gnt[1]);
  assign w_complete  = (r_state == ST_WAIT) && cache_ready;
  assign w_finish    = w_complete | w_timeout;

  rr_pick2 u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;

  // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_wd_cnt <= '0;
    else if (r_state == ST_WAIT && !cache_ready)
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    else
      r_wd_cnt <= '0;
  end

  assign w_timeout = (r_state == ST_WAIT) && !cache_ready &&
                     (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Sticky error flag once the watchdog has forced a completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_err <= 1'b0;
    else if (w_timeout)
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic; cache_ready outside WAIT has no effect
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant_any) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_finish) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cache_valid_req = 1'b0;
    busy            = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        cache_valid_req = 1'b1;
        busy            = 1'b1;
      end
      ST_WAIT:  busy = 1'b1;
      default: begin
        cache_valid_req = 1'b0;
        busy            = 1'b0;
      end
    endcase
  end

  // Latch the winner's request in IDLE; r_last resets to 1 so requester 0 has first priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= REQ_ID_0;
      r_last  <= REQ_ID_1;
      r_rw    <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE && w_grant_any) begin
      r_owner <= w_gnt_id;
      r_last  <= w_gnt_id;
      r_rw    <= (w_gnt_id == REQ_ID_1) ? r1_rw    : r0_rw;
      r_addr  <= (w_gnt_id == REQ_ID_1) ? r1_addr  : r0_addr;
      r_wdata <= (w_gnt_id == REQ_ID_1) ? r1_wdata : r0_wdata;
    end
  end

  // Completion: one-cycle done to the owner, read data captured for reads, zeroed on timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_done0 <= w_finish && (r_owner == REQ_ID_0);
      r_done1 <= w_finish && (r_owner == REQ_ID_1);
      if (w_complete && r_rw)
        r_rd_data <= cache_data_out;
      else if (w_timeout)
        r_rd_data <= '0;
    end
  end

  // Saturating hit/miss statistics; hit and miss together is a protocol error and counts neither
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_complete && (cache_hit ^ cache_miss)) begin
      if (cache_hit && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (cache_miss && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign r0_done       = r_done0;
  assign r1_done       = r_done1;
  assign rd_data       = r_rd_data;
  assign cache_rw      = r_rw;
  assign cache_addr    = r_addr;
  assign cache_data_in = r_wdata;
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;

endmodule
